// File: rtl/instr_encoder_pkg.sv
// Shared CPU table: format classes, ALU op codes and RV32I opcodes.
// The decoder imports the same package, so both sides use one encoding table.
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    FMT_R_ARITH = 4'd0,
    FMT_I_ARITH = 4'd1,
    FMT_LOAD    = 4'd2,
    FMT_STORE   = 4'd3,
    FMT_BRANCH  = 4'd4,
    FMT_JAL     = 4'd5,
    FMT_JALR    = 4'd6,
    FMT_LUI     = 4'd7,
    FMT_AUIPC   = 4'd8,
    FMT_SYSTEM  = 4'd9
  } fmt_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_NOP  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } enc_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  function automatic logic [2:0] alu_funct3(input logic [3:0] op);
    case (op)
      ALU_SLL:          return 3'b001;
      ALU_SLT:          return 3'b010;
      ALU_SLTU:         return 3'b011;
      ALU_XOR:          return 3'b100;
      ALU_SRL, ALU_SRA: return 3'b101;
      ALU_OR:           return 3'b110;
      ALU_AND:          return 3'b111;
      default:          return 3'b000;
    endcase
  endfunction

  // True when v survives truncation to a two's-complement field of 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic signed [31:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Output buffer for encoded words: DEPTH-entry FIFO, registered storage,
// simultaneous push and pop allowed.
module enc_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && (cnt_q != FULL);
  assign pop_ok  = pop_i && (cnt_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= (wr_q == LAST) ? '0 : wr_q + AW'(1);
      if (pop_ok)  rd_q <= (rd_q == LAST) ? '0 : rd_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == FULL);

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: validates and encodes one request per handshake,
// tags it with a running byte address and queues it for the consumer.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_fmt,
  input  logic [3:0]  in_alu_op,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  input  logic        err_clr,
  input  logic        restart,
  output logic        done
);

  enc_state_e  state_q;
  logic [31:0] addr_q;
  logic        err_q;

  logic [31:0] instr_enc;
  logic        illegal;
  logic [2:0]  alu_f3;
  logic [6:0]  alu_f7;
  logic        alu_ok;
  logic        is_shift;
  logic        accept;
  logic        push;
  logic [63:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_full;

  assign alu_f3   = alu_funct3(in_alu_op);
  assign alu_f7   = (in_alu_op == ALU_SUB || in_alu_op == ALU_SRA) ? F7_ALT : 7'b0000000;
  assign alu_ok   = (in_alu_op <= ALU_AND);
  assign is_shift = (in_alu_op == ALU_SLL) || (in_alu_op == ALU_SRL) || (in_alu_op == ALU_SRA);

  always_comb begin
    instr_enc = '0;
    illegal   = 1'b0;
    case (in_fmt)
      FMT_R_ARITH: begin
        illegal   = !alu_ok;
        instr_enc = {alu_f7, in_rs2, in_rs1, alu_f3, in_rd, OPC_OP};
      end
      FMT_I_ARITH: begin
        // Shifts carry a 5-bit unsigned shamt; everything else a 12-bit signed imm.
        if (is_shift) begin
          illegal   = !alu_ok || (in_imm[31:5] != '0);
          instr_enc = {alu_f7, in_imm[4:0], in_rs1, alu_f3, in_rd, OPC_OP_IMM};
        end else begin
          illegal   = !alu_ok || (in_alu_op == ALU_SUB) || !fits_signed(in_imm, 12);
          instr_enc = {in_imm[11:0], in_rs1, alu_f3, in_rd, OPC_OP_IMM};
        end
      end
      FMT_LOAD: begin
        illegal   = !(in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                    !fits_signed(in_imm, 12);
        instr_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
      end
      FMT_STORE: begin
        illegal   = (in_funct3 > 3'b010) || !fits_signed(in_imm, 12);
        instr_enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
      end
      FMT_BRANCH: begin
        illegal   = (in_funct3 == 3'b010) || (in_funct3 == 3'b011) || in_imm[0] ||
                    !fits_signed(in_imm, 13);
        instr_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], OPC_BRANCH};
      end
      FMT_JAL: begin
        illegal   = in_imm[0] || !fits_signed(in_imm, 21);
        instr_enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
      end
      FMT_JALR: begin
        illegal   = !fits_signed(in_imm, 12);
        instr_enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
      end
      FMT_LUI:    instr_enc = {in_imm[31:12], in_rd, OPC_LUI};
      FMT_AUIPC:  instr_enc = {in_imm[31:12], in_rd, OPC_AUIPC};
      FMT_SYSTEM: instr_enc = in_imm[0] ? 32'h0010_0073 : 32'h0000_0073;
      default:    illegal   = 1'b1;
    endcase
  end

  assign in_ready = (state_q == ST_RUN) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && !illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
    end else begin
      // A fresh illegal acceptance outranks a same-cycle clear.
      if (accept && illegal) err_q <= 1'b1;
      else if (err_clr)      err_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (push) begin
            addr_q <= addr_q + 32'd4;
            if (in_fmt == FMT_SYSTEM) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!fifo_valid) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (restart) begin
            state_q <= ST_RUN;
            addr_q  <= BASE_ADDR;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  enc_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(64)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .data_i ({addr_q, instr_enc}),
    .pop_i  (out_ready),
    .data_o (fifo_data),
    .valid_o(fifo_valid),
    .full_o (fifo_full)
  );

  assign out_valid = fifo_valid;
  assign out_instr = fifo_valid ? fifo_data[31:0]  : 32'h0;
  assign out_addr  = fifo_valid ? fifo_data[63:32] : 32'h0;
  assign err       = err_q;
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed scenarios plus randomized requests
// checked against a field-level RV32I reference model.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_fmt = '0;
  logic [3:0]  in_alu_op = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_addr;
  logic        err;
  logic        err_clr = 1'b0;
  logic        restart = 1'b0;
  logic        done;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_addr = BASE;
  bit          m_err = 0;
  bit          m_sys = 0;
  int          rdy_mode = 1;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_alu_op(in_alu_op), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_clr(err_clr), .restart(restart), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'h1 << (hi - lo + 1)) - 32'h1);
  endfunction

  function automatic bit in_range(input int s, input int bits);
    return (s >= -(1 << (bits - 1))) && (s < (1 << (bits - 1)));
  endfunction

  // RV32I reference: legality rules and field placement from the ISA tables.
  function automatic void model(input int fmt, input int op, input int f3,
                                input logic [31:0] rd, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [31:0] imm,
                                output bit ok, output logic [31:0] w);
    int          alu_f3_tab[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int          s;
    logic [31:0] fa, f7, ff3;
    bit          shift;
    s     = $signed(imm);
    fa    = (op <= 9) ? 32'(alu_f3_tab[op]) : 32'h0;
    f7    = (op == 1 || op == 7) ? 32'h20 : 32'h0;
    ff3   = 32'(f3);
    shift = (op == 2 || op == 6 || op == 7);
    ok    = 1;
    w     = 32'h0;
    case (fmt)
      0: begin
        ok = (op <= 9);
        w  = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (fa << 12) | (rd << 7) | 32'h33;
      end
      1: begin
        if (shift) begin
          ok = (op <= 9) && (s >= 0) && (s < 32);
          w  = (f7 << 25) | (fld(imm, 4, 0) << 20) | (rs1 << 15) | (fa << 12) | (rd << 7) | 32'h13;
        end else begin
          ok = (op <= 9) && (op != 1) && in_range(s, 12);
          w  = (fld(imm, 11, 0) << 20) | (rs1 << 15) | (fa << 12) | (rd << 7) | 32'h13;
        end
      end
      2: begin
        ok = (f3 <= 2 || f3 == 4 || f3 == 5) && in_range(s, 12);
        w  = (fld(imm, 11, 0) << 20) | (rs1 << 15) | (ff3 << 12) | (rd << 7) | 32'h03;
      end
      3: begin
        ok = (f3 <= 2) && in_range(s, 12);
        w  = (fld(imm, 11, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (ff3 << 12) |
             (fld(imm, 4, 0) << 7) | 32'h23;
      end
      4: begin
        ok = (f3 != 2) && (f3 != 3) && (imm[0] == 1'b0) && in_range(s, 13);
        w  = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (rs2 << 20) | (rs1 << 15) |
             (ff3 << 12) | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | 32'h63;
      end
      5: begin
        ok = (imm[0] == 1'b0) && in_range(s, 21);
        w  = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20) |
             (fld(imm, 19, 12) << 12) | (rd << 7) | 32'h6F;
      end
      6: begin
        ok = in_range(s, 12);
        w  = (fld(imm, 11, 0) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
      end
      7: w = (fld(imm, 31, 12) << 12) | (rd << 7) | 32'h37;
      8: w = (fld(imm, 31, 12) << 12) | (rd << 7) | 32'h17;
      9: w = imm[0] ? 32'h0010_0073 : 32'h0000_0073;
      default: ok = 0;
    endcase
  endfunction

  // Monitor: the head of the expected queue must be on the outputs whenever out_valid.
  initial begin
    logic [63:0] head;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_out: got instr %h addr %h, expected no output", out_instr, out_addr);
        end else begin
          head = exp_q[0];
          chk("out_instr", out_instr, head[31:0]);
          chk("out_addr", out_addr, head[63:32]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int fmt, input int op, input int f3, input int rd,
                      input int rs1, input int rs2, input logic [31:0] imm);
    bit          ok;
    logic [31:0] w;
    int          guard;
    model(fmt, op, f3, 32'(rd), 32'(rs1), 32'(rs2), imm, ok, w);
    in_valid  = 1'b1;
    in_fmt    = 4'(fmt);
    in_alu_op = 4'(op);
    in_funct3 = 3'(f3);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_imm    = imm;
    guard     = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'h1);
      in_valid = 1'b0;
      return;
    end
    if (ok) begin
      exp_q.push_back({m_addr, w});
      m_addr += 32'd4;
      if (fmt == 9) m_sys = 1;
    end else begin
      m_err = 1;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_addr = BASE;
    m_err  = 0;
    m_sys  = 0;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic drain_restart();
    int guard = 0;
    int saved = rdy_mode;
    rdy_mode = 1;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("done_set", 32'(done), 32'h1);
    chk("queue_at_done", 32'(exp_q.size()), 32'h0);
    chk("in_ready_done", 32'(in_ready), 32'h0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    m_addr = BASE;
    m_sys  = 0;
    chk("done_clr", 32'(done), 32'h0);
    chk("in_ready_restart", 32'(in_ready), 32'h1);
    rdy_mode = saved;
  endtask

  initial begin
    int bnd[16] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
                    31, 32, 1048574, 1048576, -1048576, -1048578, 1, 0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    tick();

    // ADD x3,x1,x2 one cycle after acceptance
    send(0, 0, 0, 3, 1, 2, 32'h0);
    chk("add_latency_valid", 32'(out_valid), 32'h1);
    chk("add_instr", out_instr, 32'h002081B3);
    chk("add_addr", out_addr, 32'h0);
    wait_empty();

    // SUB then STORE
    do_reset();
    rdy_mode = 0;
    tick();
    send(0, 1, 0, 5, 6, 7, 32'h0);
    chk("sub_instr", out_instr, 32'h407302B3);
    chk("sub_addr", out_addr, 32'h0);
    send(3, 0, 2, 0, 1, 2, 32'd8);
    rdy_mode = 1;
    wait_empty();

    // illegal branch offset, err handling
    do_reset();
    send(4, 0, 0, 0, 1, 2, 32'd3);
    chk("illegal_err", 32'(err), 32'h1);
    chk("illegal_no_valid", 32'(out_valid), 32'h0);
    tick();
    chk("illegal_no_valid2", 32'(out_valid), 32'h0);
    send(0, 0, 0, 3, 1, 2, 32'h0);
    chk("after_illegal_addr", out_addr, 32'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err = 0;
    chk("err_cleared", 32'(err), 32'h0);
    err_clr = 1'b1;
    send(4, 0, 2, 0, 1, 2, 32'd8);
    err_clr = 1'b0;
    chk("err_priority", 32'(err), 32'h1);
    wait_empty();

    // back-pressure: buffer fills after two words
    do_reset();
    rdy_mode = 0;
    tick();
    send(0, 8, 0, 1, 2, 3, 32'h0);
    send(1, 0, 0, 4, 5, 0, 32'hFFFF_FFFF);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    repeat (3) tick();
    chk("stall_addr", out_addr, 32'h0);
    fork
      begin
        repeat (2) @(posedge clk);
        rdy_mode = 1;
      end
    join_none
    send(6, 0, 0, 1, 2, 0, 32'h10);
    wait_empty();

    // SYSTEM drain and restart; restart in RUN is ignored
    do_reset();
    send(0, 0, 0, 3, 1, 2, 32'h0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_run_ignored", 32'(done), 32'h0);
    send(9, 0, 0, 0, 0, 0, 32'h0);
    chk("sys_in_ready", 32'(in_ready), 32'h0);
    drain_restart();
    send(0, 0, 0, 3, 1, 2, 32'h0);
    chk("restart_addr", out_addr, BASE);
    wait_empty();

    // reset with buffered words
    do_reset();
    rdy_mode = 0;
    tick();
    send(0, 15, 0, 1, 1, 1, 32'h0);
    send(5, 0, 0, 1, 0, 0, 32'd2048);
    send(7, 0, 0, 9, 0, 0, 32'hABCD_E000);
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_instr", out_instr, 32'h0);
    chk("midrst_err", 32'(err), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    exp_q.delete();
    m_addr = BASE;
    m_err  = 0;
    m_sys  = 0;
    @(negedge clk);
    rst = 1'b0;
    rdy_mode = 1;
    tick();
    chk("postrst_in_ready", 32'(in_ready), 32'h1);
    send(0, 0, 0, 3, 1, 2, 32'h0);
    chk("postrst_addr", out_addr, BASE);
    wait_empty();

    // randomized traffic
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      int          fmt, v;
      logic [31:0] imm;
      fmt = int'($urandom_range(0, 11));
      if (fmt == 9 && $urandom_range(0, 3) != 0) fmt = 0;
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 63)) - 32;
        1:       v = int'($urandom);
        2:       v = bnd[$urandom_range(0, 15)];
        default: v = (int'($urandom_range(0, 4000)) - 2000) & ~1;
      endcase
      imm = 32'(v);
      send(fmt, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), imm);
      chk("rand_err", 32'(err), 32'(m_err));
      if (m_sys) drain_restart();
      if ($urandom_range(0, 15) == 0) begin
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_err = 0;
        chk("rand_err_clr", 32'(err), 32'h0);
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
    rdy_mode = 1;
    wait_empty();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of the first emitted instruction.
REQ-002 SHALL have parameter DEPTH, default 2: output buffer entries, minimum 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): request handshake, transfer when both high.
REQ-006 SHALL have port in_fmt, input, 4: format class R_ARITH, I_ARITH, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM.
REQ-007 SHALL have ports in_alu_op (input, 4; ADD=0..AND=9, NOP=15), in_funct3 (input, 3), in_rd, in_rs1, in_rs2 (input, 5 each), in_imm (input, 32).
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_instr (output, 32), out_addr (output, 32): encoded word and its byte address.
REQ-009 SHALL have ports err (output, 1, sticky illegal request), err_clr (input, 1), restart (input, 1), done (output, 1).

Function
REQ-010 SHALL encode per RV32I: R uses funct7 0100000 for SUB/SRA, else 0000000; funct3 derived from alu_op for R/I arith.
REQ-011 SHALL encode I_ARITH imm[11:0]; SLL/SRL/SRA use imm[4:0] as shamt with funct7 as in REQ-010.
REQ-012 SHALL encode LOAD/STORE/BRANCH funct3 from in_funct3; STORE splits imm[11:5]/[4:0]; BRANCH packs imm[12|10:5|4:1|11]; JAL packs imm[20|10:1|11|19:12]; JALR funct3=000; LUI/AUIPC use imm[31:12]; SYSTEM emits 0x00000073 (imm[0]=0) or 0x00100073 (imm[0]=1).
REQ-013 SHALL flag illegal: alu_op NOP/undefined for arith; SUB in I_ARITH; LOAD funct3 not in {000,001,010,100,101}; STORE funct3 >010; BRANCH funct3 010/011; BRANCH/JAL imm[0]=1; imm outside signed range of its field.
REQ-014 SHALL accept illegal requests (handshake completes), discard them, set err, and leave the address counter unchanged.
REQ-015 SHALL drive in_ready = (state==RUN) and (buffer count < DEPTH), independent of out_ready in the same cycle.
REQ-016 SHALL present an accepted legal request on out_valid exactly one cycle after acceptance when the buffer was empty (registered, no combinational bypass).
REQ-017 SHALL keep out_instr/out_addr stable while out_valid=1 and out_ready=0; pop on out_valid&out_ready, FIFO order.
REQ-018 SHALL permit simultaneous push and pop in one cycle; count unchanged.
REQ-019 SHALL assign out_addr from an address counter at acceptance, then increment by 4, wrapping modulo 2^32.
REQ-020 SHALL implement states RUN, DRAIN, DONE: RUN->DRAIN on accepting a legal SYSTEM request; DRAIN->DONE when buffer empty; DONE->RUN on restart.
REQ-021 SHALL assert done only in DONE; restart in DONE reloads counter to BASE_ADDR; restart in RUN/DRAIN is ignored.
REQ-022 SHALL clear err on err_clr; a same-cycle new illegal acceptance takes priority and leaves err=1.

Reset
REQ-023 SHALL on rst: state=RUN, buffer empty, out_valid=0, out_instr=0, out_addr=0, err=0, done=0, counter=BASE_ADDR, in_ready=1 after release.
REQ-024 SHALL discard all buffered words on reset mid-operation; no partial output after release.

Structure
REQ-025 SHALL take opcode constants, the format-class enum and ALU op codes from the shared CPU package used by the decoder, so encoder and decoder agree on one table.
REQ-026 SHALL place the output buffer in sub-module enc_fifo (parameter DEPTH, WIDTH=64); encode logic and FSM stay in instr_encoder.

Verification
REQ-027 SHALL cover: R_ARITH ADD rd=3 rs1=1 rs2=2 after reset -> out_instr 0x002081B3, out_addr 0x00000000 one cycle later.
REQ-028 SHALL cover: R_ARITH SUB rd=5 rs1=6 rs2=7 then STORE funct3=010 rs1=1 rs2=2 imm=8 -> 0x407302B3 @0x0, 0x0020A423 @0x4.
REQ-029 SHALL cover: BRANCH funct3=000 imm=3 -> err=1, no out_valid, next legal word @ unchanged address; err_clr -> err=0.
REQ-030 SHALL cover: out_ready=0, three back-to-back requests -> in_ready low after two; out_ready=1 -> words emerge in order, addresses 0x0,0x4,0x8.
REQ-031 SHALL cover: SYSTEM imm=0 -> 0x00000073 emitted, in_ready=0, done=1 after drain; restart -> RUN, next word @BASE_ADDR.
REQ-032 SHALL cover: rst asserted with two buffered words -> out_valid=0 immediately, err=0, counter=BASE_ADDR.
